dekatron_step_sequencer: RTL and testbench
==========================================

// Module: dekatron_step_sequencer
// PURPOSE
//  Sequences a chain of DIGITS dekatron stages (pulse sender + bulb per digit) as one decimal counter.
//  Accepts INC/DEC/CLEAR commands, pulses the LSD, waits for glow to settle, ripples carry/borrow upward.
//  Sits between the CPU control unit and the dekatron datapath.
//  Owns every per-digit En/Reverse/Set line.
// PARAMETERS
//  DIGITS        6    number of chained dekatron digits (>=1)
//  PULSE_CYCLES  3    clocks DigitEn is held per step (NONE->RIGHT->LEFT->NONE sender sequence)
//  SET_CYCLES    2    clocks DigitSet is held for CLEAR
//  TIMEOUT       255  max WAIT clocks before Error; counter width = $clog2(TIMEOUT+1)
// PORTS
//  Clk        in   1          system clock, all logic on posedge
//  Rst        in   1          synchronous, active-high reset
//  Req        in   1          command request, level-sampled
//  Op         in   2          00 INC, 01 DEC, 10 CLEAR, 11 NOP
//  Busy       out  1          command in progress
//  Done       out  1          one-clock completion pulse
//  Error      out  1          settle timeout on last command, sticky until next accept
//  Carry      out  1          last INC overflowed MSD (9..9->0..0) or DEC underflowed (0..0->9..9)
//  DigitEn    out  DIGITS     per-digit pulse-sender enable
//  Reverse    out  1          shared step direction, 1 = decrement
//  DigitSet   out  DIGITS     per-digit bulb Set strobe
//  SetValue   out  10         one-hot load value, 10'b0000000001 during CLEAR, else 0
//  DigitIn    in   DIGITS*10  one-hot bulb outputs, digit i at [10*i+9:10*i]
//  DigitReady in   DIGITS     per-digit bulb Ready (glow on main cathode, no pulse active)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, idx=0. Mid-command reset drops DigitEn at that edge, so senders return to NONE.
//  States: IDLE, PULSE, WAIT, LOAD, WAITALL, DONE.
//  IDLE: Busy=0. Req=1 at an edge = accept.
//   - Accept latches Op, clears Error and Carry, sets Busy=1 from the next cycle.
//   - INC/DEC: idx=0 -> PULSE.
//   - CLEAR: -> LOAD.
//   - NOP: -> DONE.
//  Req while Busy or in DONE: ignored, not queued.
//  PULSE entry: snapshot Wrap = DigitIn[idx] digit 9 (INC) or digit 0 (DEC).
//   - DigitEn[idx]=1 for exactly PULSE_CYCLES clocks; Reverse = (Op==DEC), held stable for the whole command.
//   - Then -> WAIT.
//  WAIT: DigitEn=0; timeout counter counts clocks from 0.
//   - Settled = DigitReady[idx] & DigitIn[idx] exactly one-hot.
//   - Settled and !Wrap -> DONE.
//   - Settled, Wrap, idx<DIGITS-1 -> idx+1, -> PULSE.
//   - Settled, Wrap, idx==DIGITS-1 -> Carry=1, -> DONE.
//   - Counter reaches TIMEOUT unsettled -> Error=1, -> DONE. Higher digits are untouched.
//  LOAD: DigitSet = all ones, SetValue = 10'b1, for SET_CYCLES clocks; DigitEn=0. Then -> WAITALL.
//  WAITALL: same timeout rule; requires all digits settled. Carry is never set by CLEAR.
//  DONE: Done=1, Busy=0 for one clock, -> IDLE. Error and Carry hold until next accept.
//  Only one digit's DigitEn is high at any time. DigitEn and DigitSet are never high together.
//  Latency, INC without carry, Ready immediate: Done is high in the cycle PULSE_CYCLES+2 after the accepting edge.
//   Each carry stage adds PULSE_CYCLES+1 cycles.
// TESTING
//  1. DIGITS=3, value 000, Ready model settles 1 clk after pulse; INC -> digit0=1, Done after 5 clk, Carry=0, Error=0.
//  2. Value 199; INC -> DigitEn pulses digits 0,1,2 in order, Reverse=0; result 200, Carry=0.
//  3. Value 999; INC -> all digits pulsed, result 000, Carry=1. Then DEC from 000 -> 999, Reverse=1, Carry=1.
//  4. Digit1 model never asserts Ready; value 009, INC -> Error=1 exactly TIMEOUT clks into WAIT.
//     Digit2 never enabled; Error clears on next accepted Req.
//  5. Value 457; CLEAR -> DigitSet=111 for 2 clk, SetValue=10'b1; result 000, Done, Carry=0.
//  6. Rst=1 during second PULSE clk of INC -> next cycle all outputs 0, state IDLE.
//     Req asserted during Busy has no effect.

Source files
------------

// File: rtl/dekatron_step_sequencer_if.sv
// Command and digit-datapath bundle for dekatron_step_sequencer.
//
// Signal names carry the direction as seen from the sequencer:
//   i_req          command request, level-sampled in IDLE
//   i_op           00 INC, 01 DEC, 10 CLEAR, 11 NOP
//   o_busy         command in progress
//   o_done         one-clock completion pulse
//   o_error        settle timeout on last command, sticky until next accept
//   o_carry        last INC overflowed / DEC underflowed the whole chain
//   o_digit_en     per-digit pulse-sender enable
//   o_reverse      shared step direction, 1 = decrement
//   o_digit_set    per-digit bulb Set strobe
//   o_set_value    one-hot load value driven while the Set strobe is high
//   i_digit_in     one-hot bulb outputs, digit i at [10*i+9:10*i]
//   i_digit_ready  per-digit bulb Ready
//
// master: CPU control unit + dekatron datapath side.
// slave : the sequencer.
interface dekatron_step_sequencer_if #(
    parameter int DIGITS = 6
);
    logic                 i_req;
    logic [1:0]           i_op;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_error;
    logic                 o_carry;
    logic [DIGITS-1:0]    o_digit_en;
    logic                 o_reverse;
    logic [DIGITS-1:0]    o_digit_set;
    logic [9:0]           o_set_value;
    logic [DIGITS*10-1:0] i_digit_in;
    logic [DIGITS-1:0]    i_digit_ready;

    modport master (
        output i_req, i_op, i_digit_in, i_digit_ready,
        input  o_busy, o_done, o_error, o_carry, o_digit_en,
               o_reverse, o_digit_set, o_set_value
    );

    modport slave (
        input  i_req, i_op, i_digit_in, i_digit_ready,
        output o_busy, o_done, o_error, o_carry, o_digit_en,
               o_reverse, o_digit_set, o_set_value
    );
endinterface

// File: rtl/dekatron_step_sequencer.sv
// Sequences a chain of DIGITS dekatron stages as one decimal counter.
// INC/DEC pulse the least significant digit, wait for the glow to settle
// and ripple carry/borrow upward; CLEAR strobes every bulb to zero.
//
// Ports:
//   i_clk  system clock, all logic on posedge
//   i_rst  synchronous active-high reset
//   bus    dekatron_step_sequencer_if.slave (command handshake + digit lines)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for i_req; accept latches the op
// PULSE   | digit idx sender enabled for PULSE_CYCLES clocks
// WAIT    | digit idx must settle (Ready + one-hot) before timeout
// LOAD    | all Set strobes high for SET_CYCLES clocks, value = 0
// WAITALL | every digit must settle before timeout
// DONE    | one-clock completion pulse
module dekatron_step_sequencer #(
    parameter int DIGITS       = 6,
    parameter int PULSE_CYCLES = 3,
    parameter int SET_CYCLES   = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    dekatron_step_sequencer_if.slave bus
);

    localparam logic [1:0] OP_INC   = 2'b00;
    localparam logic [1:0] OP_DEC   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TMR_MAX = (TIMEOUT > PULSE_CYCLES) ?
                             ((TIMEOUT > SET_CYCLES) ? TIMEOUT : SET_CYCLES) :
                             ((PULSE_CYCLES > SET_CYCLES) ? PULSE_CYCLES : SET_CYCLES);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PULSE   = 3'd1,
        S_WAIT    = 3'd2,
        S_LOAD    = 3'd3,
        S_WAITALL = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic [TMR_W-1:0]   r_tmr;
    logic [1:0]         r_op;
    logic               r_wrap;
    logic               r_error;
    logic               r_carry;

    logic               w_accept;
    logic               w_tmr_zero;
    logic               w_last;
    logic [9:0]         w_cur_digit;
    logic               w_cur_ready;
    logic               w_settled_cur;
    logic               w_settled_all;
    logic [IDX_W-1:0]   w_pulse_idx;
    logic [9:0]         w_pulse_digit;
    logic [1:0]         w_eff_op;

    function automatic logic is_onehot(input logic [9:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int b = 0; b < 10; b++) begin
            cnt = cnt + {3'b000, v[b]};
        end
        return (cnt == 4'd1);
    endfunction

    assign w_accept   = (r_state == S_IDLE) && bus.i_req;
    assign w_tmr_zero = (r_tmr == '0);
    assign w_last     = (r_idx == IDX_W'(DIGITS - 1));
    // The op in force at PULSE entry: the incoming one on the accepting edge.
    assign w_eff_op   = (r_state == S_IDLE) ? bus.i_op : r_op;
    // Digit about to be pulsed: 0 on accept, idx+1 on a carry ripple.
    assign w_pulse_idx = (r_state == S_IDLE) ? '0 : r_idx + IDX_W'(1);

    always_comb begin
        w_cur_digit   = '0;
        w_cur_ready   = 1'b0;
        w_pulse_digit = '0;
        w_settled_all = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_cur_digit = bus.i_digit_in[i*10 +: 10];
                w_cur_ready = bus.i_digit_ready[i];
            end
            if (w_pulse_idx == IDX_W'(i)) begin
                w_pulse_digit = bus.i_digit_in[i*10 +: 10];
            end
            if (!(bus.i_digit_ready[i] && is_onehot(bus.i_digit_in[i*10 +: 10]))) begin
                w_settled_all = 1'b0;
            end
        end
    end

    assign w_settled_cur = w_cur_ready && is_onehot(w_cur_digit);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.i_req) begin
                    case (bus.i_op)
                        OP_INC, OP_DEC: w_next = S_PULSE;
                        OP_CLEAR:       w_next = S_LOAD;
                        default:        w_next = S_DONE;
                    endcase
                end
            end
            S_PULSE: begin
                if (w_tmr_zero) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_settled_cur) begin
                    if (r_wrap && !w_last) w_next = S_PULSE;
                    else                   w_next = S_DONE;
                end else if (w_tmr_zero) begin
                    w_next = S_DONE;
                end
            end
            S_LOAD: begin
                if (w_tmr_zero) w_next = S_WAITALL;
            end
            S_WAITALL: begin
                if (w_settled_all || w_tmr_zero) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: index, shared down-counter, wrap snapshot, status flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx   <= '0;
            r_tmr   <= '0;
            r_op    <= '0;
            r_wrap  <= 1'b0;
            r_error <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= bus.i_op;
                r_error <= 1'b0;
                r_carry <= 1'b0;
                r_idx   <= '0;
            end

            // The counter is reloaded on every state entry so each phase
            // starts its own budget; terminal count is zero.
            if (w_next != r_state) begin
                case (w_next)
                    S_PULSE:           r_tmr <= TMR_W'(PULSE_CYCLES - 1);
                    S_LOAD:            r_tmr <= TMR_W'(SET_CYCLES - 1);
                    S_WAIT, S_WAITALL: r_tmr <= TMR_W'(TIMEOUT - 1);
                    default:           r_tmr <= '0;
                endcase
            end else if (!w_tmr_zero) begin
                r_tmr <= r_tmr - TMR_W'(1);
            end

            // Wrap is decided from the glow before the pulse moves it.
            if ((w_next == S_PULSE) && (r_state != S_PULSE)) begin
                r_idx  <= w_pulse_idx;
                r_wrap <= (w_eff_op == OP_DEC) ? w_pulse_digit[0] : w_pulse_digit[9];
            end

            if ((r_state == S_WAIT) && w_settled_cur && r_wrap && w_last) begin
                r_carry <= 1'b1;
            end

            if (((r_state == S_WAIT) && !w_settled_cur && w_tmr_zero) ||
                ((r_state == S_WAITALL) && !w_settled_all && w_tmr_zero)) begin
                r_error <= 1'b1;
            end
        end
    end

    // Output logic
    always_comb begin
        bus.o_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
        bus.o_done      = (r_state == S_DONE);
        bus.o_error     = r_error;
        bus.o_carry     = r_carry;
        bus.o_reverse   = bus.o_busy && (r_op == OP_DEC);
        bus.o_digit_set = (r_state == S_LOAD) ? {DIGITS{1'b1}} : '0;
        bus.o_set_value = (r_state == S_LOAD) ? 10'b0000000001 : 10'b0;
        bus.o_digit_en  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bus.o_digit_en[i] = (r_state == S_PULSE) && (r_idx == IDX_W'(i));
        end
    end

endmodule

// File: tb/tb_dekatron_step_sequencer.sv
// Bench for dekatron_step_sequencer: a behavioural dekatron chain drives the
// digit lines, a table of directed commands and a randomized run are checked
// against decimal-arithmetic expectations, plus timeout and reset sequences.
module tb_dekatron_step_sequencer;

    localparam int DIGITS = 3;
    localparam int PC     = 3;
    localparam int SC     = 2;
    localparam int TO     = 255;
    localparam int MOD    = 1000;

    localparam logic [1:0] INC   = 2'b00;
    localparam logic [1:0] DEC   = 2'b01;
    localparam logic [1:0] CLR   = 2'b10;
    localparam logic [1:0] NOP   = 2'b11;

    logic clk;
    logic rst;

    dekatron_step_sequencer_if #(.DIGITS(DIGITS)) bus ();

    dekatron_step_sequencer #(
        .DIGITS(DIGITS), .PULSE_CYCLES(PC), .SET_CYCLES(SC), .TIMEOUT(TO)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- dekatron chain model ----------------
    int  val     [DIGITS] = '{default: 0};
    bit  pend    [DIGITS] = '{default: 0};
    bit  prev_rev[DIGITS] = '{default: 0};
    bit  setp    [DIGITS] = '{default: 0};
    bit  stuck   [DIGITS] = '{default: 0};
    int  pulses  [DIGITS] = '{default: 0};
    int  en_cyc  = 0;
    int  rev_cyc = 0;
    int  set_cyc = 0;
    int  viol    = 0;
    int  pre_seq = 0;
    int  seen_seq = 0;
    int  pre_val = 0;
    int  mt;

    always @(negedge clk) begin
        if (pre_seq != seen_seq) begin
            seen_seq = pre_seq;
            mt = pre_val;
            for (int i = 0; i < DIGITS; i++) begin
                val[i] = mt % 10;
                mt = mt / 10;
                pend[i] = 0;
                setp[i] = 0;
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.o_digit_en[i]) begin
                if (!pend[i]) pulses[i]++;
                pend[i] = 1;
                prev_rev[i] = bus.o_reverse;
            end else if (pend[i]) begin
                pend[i] = 0;
                val[i] = prev_rev[i] ? (val[i] + 9) % 10 : (val[i] + 1) % 10;
            end
            if (bus.o_digit_set[i]) begin
                val[i] = 0;
                setp[i] = 1;
            end else begin
                setp[i] = 0;
            end
        end
        if (|bus.o_digit_en) begin
            en_cyc++;
            if (bus.o_reverse) rev_cyc++;
        end
        if ($countones(bus.o_digit_en) > 1) viol++;
        if ((|bus.o_digit_en) && (|bus.o_digit_set)) viol++;
        if (|bus.o_digit_set) begin
            set_cyc++;
            if (bus.o_set_value != 10'd1 || bus.o_digit_set != {DIGITS{1'b1}}) viol++;
        end else if (bus.o_set_value != 10'd0) begin
            viol++;
        end
    end

    always_comb begin
        bus.i_digit_in    = '0;
        bus.i_digit_ready = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bus.i_digit_in[i*10 +: 10] = 10'b1 << val[i];
            bus.i_digit_ready[i]       = !pend[i] && !setp[i] && !stuck[i];
        end
    end

    // ---------------- reference model ----------------
    function automatic int ref_stages(input logic [1:0] op, input int v);
        int s, t, d;
        if (op == CLR || op == NOP) return 0;
        d = (op == INC) ? 9 : 0;
        s = 1;
        t = v;
        while ((t % 10 == d) && (s < DIGITS)) begin
            s++;
            t = t / 10;
        end
        return s;
    endfunction

    function automatic int ref_val(input logic [1:0] op, input int v);
        case (op)
            INC:     return (v + 1) % MOD;
            DEC:     return (v + MOD - 1) % MOD;
            CLR:     return 0;
            default: return v;
        endcase
    endfunction

    function automatic bit ref_carry(input logic [1:0] op, input int v);
        return ((op == INC) && (v == MOD - 1)) || ((op == DEC) && (v == 0));
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input int v);
        case (op)
            INC, DEC: return ref_stages(op, v) * (PC + 1) + 1;
            CLR:      return SC + 2;
            default:  return 1;
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    function automatic int model_value();
        int r, m;
        r = 0;
        m = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r = r + val[i] * m;
            m = m * 10;
        end
        return r;
    endfunction

    function automatic int pulse_sum();
        int s;
        s = 0;
        for (int i = 0; i < DIGITS; i++) s = s + pulses[i];
        return s;
    endfunction

    task automatic run_cmd(input logic [1:0] op, input int v, input bit hold,
                           output int lat, output int res, output bit c,
                           output bit e, output bit b1, output int pd,
                           output int ed, output int rd, output int sd);
        int p0, e0, r0, s0;
        @(posedge clk); #1;
        pre_val = v;
        pre_seq++;
        @(negedge clk);
        p0 = pulse_sum(); e0 = en_cyc; r0 = rev_cyc; s0 = set_cyc;
        bus.i_op  = op;
        bus.i_req = 1'b1;
        @(posedge clk);
        lat = -1;
        b1  = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (k == 1) begin
                b1 = bus.o_busy;
                if (!hold) bus.i_req = 1'b0;
            end
            if (bus.o_done) begin
                lat = k;
                break;
            end
        end
        bus.i_req = 1'b0;
        if (lat < 0) $display("FAIL done_wait act=%0d exp=%0d", 0, 1);
        res = model_value();
        c   = bus.o_carry;
        e   = bus.o_error;
        pd  = pulse_sum() - p0;
        ed  = en_cyc - e0;
        rd  = rev_cyc - r0;
        sd  = set_cyc - s0;
    endtask

    task automatic check_cmd(input string tag, input logic [1:0] op, input int v,
                             input bit hold, input int exp_res, input bit exp_c,
                             input int exp_lat);
        int lat, res, pd, ed, rd, sd, st;
        bit c, e, b1;
        run_cmd(op, v, hold, lat, res, c, e, b1, pd, ed, rd, sd);
        st = ref_stages(op, v);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_value"},   res, exp_res);
        chk({tag, "_carry"},   int'(c), int'(exp_c));
        chk({tag, "_error"},   int'(e), 0);
        chk({tag, "_busy1"},   int'(b1), (exp_lat > 1) ? 1 : 0);
        chk({tag, "_pulses"},  pd, st);
        chk({tag, "_en_cyc"},  ed, st * PC);
        chk({tag, "_rev_cyc"}, rd, (op == DEC) ? st * PC : 0);
        chk({tag, "_set_cyc"}, sd, (op == CLR) ? SC : 0);
    endtask

    typedef struct {
        logic [1:0] op;
        int         v;
        int         exp_res;
        bit         exp_c;
        int         exp_lat;
    } vec_t;

    vec_t tbl [8];

    int  lat, res, pd, ed, rd, sd, p2_0, busy_cnt, err_before;
    bit  c, e, b1;
    logic [1:0] rop;
    int  rv;

    initial begin
        tbl[0] = '{INC, 0,   1,   1'b0, 5};
        tbl[1] = '{INC, 199, 200, 1'b0, 13};
        tbl[2] = '{INC, 999, 0,   1'b1, 13};
        tbl[3] = '{DEC, 0,   999, 1'b1, 13};
        tbl[4] = '{CLR, 457, 0,   1'b0, 4};
        tbl[5] = '{NOP, 321, 321, 1'b0, 1};
        tbl[6] = '{DEC, 450, 449, 1'b0, 9};
        tbl[7] = '{INC, 59,  60,  1'b0, 9};

        rst = 1'b1;
        bus.i_req = 1'b0;
        bus.i_op  = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            int'({bus.o_busy, bus.o_done, bus.o_error, bus.o_carry, bus.o_reverse,
                  bus.o_digit_en, bus.o_digit_set, bus.o_set_value}), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            check_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].v, 1'b0,
                      tbl[i].exp_res, tbl[i].exp_c, tbl[i].exp_lat);
        end

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            rv  = int'($urandom_range(0, MOD - 1));
            if (i % 8 == 0) rv = (i % 16 == 0) ? MOD - 1 : 0;
            check_cmd($sformatf("rnd%0d", i), rop, rv, 1'b0,
                      ref_val(rop, rv), ref_carry(rop, rv), ref_lat(rop, rv));
        end

        // Digit1 never settles: timeout while waiting on it, digit2 untouched.
        @(posedge clk); #1;
        stuck[1] = 1;
        p2_0 = pulses[2];
        pre_val = 9;
        pre_seq++;
        @(negedge clk);
        bus.i_op  = INC;
        bus.i_req = 1'b1;
        @(posedge clk);
        lat = -1;
        err_before = 0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (k == 1) bus.i_req = 1'b0;
            if (bus.o_done) begin
                lat = k;
                break;
            end
            err_before = err_before | int'(bus.o_error);
        end
        chk("timeout_latency", lat, 2 * (PC + 1) + TO);
        chk("timeout_error", int'(bus.o_error), 1);
        chk("timeout_no_early_error", err_before, 0);
        chk("timeout_carry", int'(bus.o_carry), 0);
        chk("timeout_digit2_untouched", pulses[2] - p2_0, 0);
        repeat (2) @(negedge clk);
        chk("error_sticky_idle", int'(bus.o_error), 1);
        stuck[1] = 0;
        run_cmd(NOP, 0, 1'b0, lat, res, c, e, b1, pd, ed, rd, sd);
        chk("error_cleared_on_accept", int'(e), 0);
        chk("nop_after_timeout_latency", lat, 1);

        // Reset during the second PULSE clock.
        @(posedge clk); #1;
        pre_val = 0;
        pre_seq++;
        @(negedge clk);
        bus.i_op  = INC;
        bus.i_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_req = 1'b0;
        chk("rst_pre_digit_en", int'(bus.o_digit_en), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs",
            int'({bus.o_busy, bus.o_done, bus.o_error, bus.o_carry, bus.o_reverse,
                  bus.o_digit_en, bus.o_digit_set, bus.o_set_value}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_stays_idle", int'(bus.o_busy), 0);

        // Req held through the whole command must not re-trigger it.
        check_cmd("hold_req", INC, 42, 1'b1, 43, 1'b0, 5);
        busy_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            busy_cnt = busy_cnt + int'(bus.o_busy) + int'(bus.o_done);
        end
        chk("hold_req_no_requeue", busy_cnt, 0);
        chk("hold_req_value_after", model_value(), 43);

        chk("exclusivity_violations", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
